// File: rtl/uart_rx_frame_decoder.sv
// Oversampling UART receive deframer: 5-8 data bits, optional parity, 1/2 stop bits,
// break detection, single-entry valid/ready output register with overrun pulse.
module uart_rx_frame_decoder #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_tick,
    input  logic       rx_in,
    input  logic [3:0] cfg_data_bits,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_odd,
    input  logic       cfg_stop2,
    output logic [7:0] m_data,
    output logic       m_frame_err,
    output logic       m_parity_err,
    output logic       m_break,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       overrun
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [TW-1:0]          r_tick;
    logic [2:0]             r_bit_idx;
    logic [2:0]             r_last_idx;
    logic                   r_par_en;
    logic                   r_par_odd;
    logic                   r_stop2;
    logic                   r_stop_idx;
    logic [7:0]             r_shift;
    logic                   r_s0;
    logic                   r_s1;
    logic                   r_zero;
    logic                   r_perr;
    logic                   r_ferr;
    logic [7:0]             r_data;
    logic                   r_frame_err;
    logic                   r_parity_err;
    logic                   r_break;
    logic                   r_valid;
    logic                   r_overrun;

    logic          w_rx_s;
    logic [TW-1:0] w_tick_idx;
    logic          w_maj;
    logic          w_dec;
    logic          w_par_exp;
    logic          w_brk;
    logic [2:0]    w_last_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
    end

    always_comb begin
        w_rx_s     = r_sync[SYNC_STAGES-1];
        w_tick_idx = (r_tick == T_LAST) ? '0 : r_tick + 1'b1;
        w_dec      = (w_tick_idx == T_DEC);
        w_maj      = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
        w_par_exp  = ^r_shift ^ r_par_odd;
        // With two stop bits the first one is already folded into r_zero
        w_brk      = r_stop_idx ? r_zero : (r_zero & ~w_maj);
        if (cfg_data_bits < 4'd5)      w_last_idx = 3'd4;
        else if (cfg_data_bits > 4'd8) w_last_idx = 3'd7;
        else                           w_last_idx = 3'(cfg_data_bits - 4'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tick       <= '0;
            r_bit_idx    <= '0;
            r_last_idx   <= 3'd7;
            r_par_en     <= 1'b0;
            r_par_odd    <= 1'b0;
            r_stop2      <= 1'b0;
            r_stop_idx   <= 1'b0;
            r_shift      <= '0;
            r_s0         <= 1'b1;
            r_s1         <= 1'b1;
            r_zero       <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_data       <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_break      <= 1'b0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_valid && m_ready) r_valid <= 1'b0;
            if (sample_tick) begin
                r_tick <= w_tick_idx;
                if (w_tick_idx == T_S0) r_s0 <= w_rx_s;
                if (w_tick_idx == T_S1) r_s1 <= w_rx_s;
                case (r_state)
                    IDLE: begin
                        if (!w_rx_s) begin
                            r_state    <= START;
                            r_tick     <= '0;
                            r_last_idx <= w_last_idx;
                            r_par_en   <= cfg_parity_en;
                            r_par_odd  <= cfg_parity_odd;
                            r_stop2    <= cfg_stop2;
                            r_stop_idx <= 1'b0;
                            r_shift    <= '0;
                            r_bit_idx  <= '0;
                            r_zero     <= 1'b1;
                            r_perr     <= 1'b0;
                            r_ferr     <= 1'b0;
                        end
                    end
                    START: begin
                        if (w_dec && w_maj)            r_state <= IDLE;
                        else if (w_tick_idx == T_LAST) r_state <= DATA;
                    end
                    DATA: begin
                        if (w_dec) begin
                            r_shift[r_bit_idx] <= w_maj;
                            if (w_maj) r_zero <= 1'b0;
                        end
                        if (w_tick_idx == T_LAST) begin
                            if (r_bit_idx == r_last_idx) r_state <= r_par_en ? PARITY : STOP;
                            else                         r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (w_dec) begin
                            if (w_maj != w_par_exp) r_perr <= 1'b1;
                            if (w_maj) r_zero <= 1'b0;
                        end
                        if (w_tick_idx == T_LAST) r_state <= STOP;
                    end
                    STOP: begin
                        if (w_dec) begin
                            if (r_stop2 && !r_stop_idx) begin
                                if (!w_maj) r_ferr <= 1'b1;
                                if (w_maj)  r_zero <= 1'b0;
                            end else begin
                                // Complete at the decision tick so the next start edge can resync
                                r_state <= w_brk ? BRK : IDLE;
                                if (!r_valid || m_ready) begin
                                    r_valid      <= 1'b1;
                                    r_data       <= w_brk ? '0 : r_shift;
                                    r_frame_err  <= w_brk | r_ferr | ~w_maj;
                                    r_parity_err <= r_perr;
                                    r_break      <= w_brk;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end
                        end
                        if (w_tick_idx == T_LAST && r_stop2 && !r_stop_idx) r_stop_idx <= 1'b1;
                    end
                    BRK: begin
                        if (w_rx_s) r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign m_data       = r_data;
    assign m_frame_err  = r_frame_err;
    assign m_parity_err = r_parity_err;
    assign m_break      = r_break;
    assign m_valid      = r_valid;
    assign overrun      = r_overrun;
endmodule

// File: doc/uart_rx_frame_decoder.md
# uart_rx_frame_decoder

Parametrised, oversampling UART receive deframer: the next-generation replacement for the fixed 8N1 baud-tick RX shift register. Synchronises the raw RX pin, finds the start bit on a 16x (configurable) sample tick and majority-votes each bit at mid-point. Supports 5–8 data bits, optional even/odd parity and 1 or 2 stop bits, and detects break. Output is a single-entry valid/ready register that feeds the RX FIFO together with per-byte error flags.

## Interface
- OVERSAMPLE, 16: sample ticks per bit; even, ≥ 4.
- SYNC_STAGES, 2: flops in the rx_in synchroniser; ≥ 2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-cycle pulse, OVERSAMPLE per bit-time.
- rx_in  in  1  raw serial input, idle high.
- cfg_data_bits  in  4  data bits per frame, 5–8; values < 5 act as 5, values > 8 act as 8.
- cfg_parity_en  in  1  parity bit present.
- cfg_parity_odd  in  1  1 = odd parity, 0 = even.
- cfg_stop2  in  1  1 = two stop bits.
- m_data  out  8  received byte, LSB-aligned, upper unused bits 0.
- m_frame_err  out  1  stop bit(s) sampled low; qualified by m_valid.
- m_parity_err  out  1  parity mismatch; qualified by m_valid.
- m_break  out  1  frame was a break; qualified by m_valid.
- m_valid  out  1  output register holds an unread frame.
- m_ready  in  1  consumer accepts when m_valid && m_ready.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.

## Operation
- rx_s is rx_in after SYNC_STAGES flops (reset value 1). All decoding uses rx_s and advances only on sample_tick.
- tick_cnt has width $clog2(OVERSAMPLE). It runs 0..OVERSAMPLE-1 within each bit and wraps to 0 at the bit boundary.
- Bit value = majority of rx_s at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, decided at tick OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK.
  - IDLE: on a tick with rx_s=0, latch cfg_* into internal shadow registers, clear the shift register and go to START with tick_cnt=0. That tick counts as tick 0.
  - START: if the majority is 1 at the decision tick, it is a false start; return to IDLE and emit no frame. Otherwise stay until the bit end, then go to DATA.
  - DATA: shift bits in LSB first; bit_idx runs 0..N-1. After bit N-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: expected bit = XOR(data) XOR cfg_parity_odd. A mismatch sets parity_err.
  - STOP: a low sample sets frame_err.
    - With cfg_stop2, the first stop bit runs to its bit end and the second is then sampled too.
    - The frame completes at the decision tick of the last stop bit. It does not wait for the bit end, which allows back-to-back frames to resync. The FSM goes to IDLE, or to BRK if break.
  - Break = all data bits, the parity bit (if enabled) and the first stop bit sampled 0. Set m_break=1 and m_frame_err=1, m_data=0. Go to BRK.
  - BRK: stay until a tick sees rx_s=1, then go to IDLE. No further frames are emitted during BRK.
- Mid-frame cfg_* changes have no effect until the next start bit.
- Output register on frame completion:
  - m_valid=0, or m_valid=1 with m_ready=1 in the same cycle: load data and flags, m_valid=1.
  - m_valid=1 with m_ready=0: keep the old contents, drop the new frame, pulse overrun.
- A handshake with no completion clears m_valid. The m_data and flag values are don't-care when m_valid=0.

## Timing
- Reset values: m_data=0, all flags 0, m_valid=0, overrun=0, FSM=IDLE, rx_s=1, shadow config=8N1.
- m_valid and flags rise one clk after the completing sample_tick.
- For frames after a start edge on rx_in, add SYNC_STAGES clk cycles of edge-detect latency.
- overrun is high exactly one clk, the same cycle m_valid would have been reloaded.
- Reset asserted mid-frame aborts immediately; the frame in progress is lost and no overrun is reported.
- A sample_tick coincident with reset release is ignored.
- m_ready has no effect while m_valid=0.

## Test plan
- OVERSAMPLE=16, 8N1, send 0xA5 then 0x3C back-to-back, m_ready=1 -> two m_valid pulses, m_data 0xA5 then 0x3C, no error flags.
- 7E1, send 0x55 with parity bit forced to 1 -> m_data=0x55, m_parity_err=1. Repeat with correct parity 0 -> m_parity_err=0.
- 8N2, second stop bit driven low -> m_frame_err=1. Low for 5 ticks, then high (glitch) -> no frame, FSM back in IDLE.
- Line held low for 20 bit-times, then high -> exactly one frame with m_data=0x00, m_break=1, m_frame_err=1. The next 0x81 after the line returns high is received correctly.
- m_ready=0, send 0x11 then 0x22 -> m_data stays 0x11, overrun pulses 1 clk at the second completion. Raising m_ready on the same cycle as a third completion (0x33) -> 0x11 is accepted, 0x33 is loaded, no overrun.
- Assert rst during data bit 4 of a frame -> outputs go to reset values immediately. After release, a fresh 0xC3 is received cleanly.
